// File: rtl/key_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// frame classification and the column drive rotation.
package key_scan_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    REL_DB
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_t;

  typedef struct packed {
    frame_res_t       res;
    logic [KEY_W-1:0] key;
  } frame_t;

  localparam logic [3:0] COL_PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // lows[row*4+col] is set when that row read low while that column was driven.
  function automatic frame_t classify(input logic [15:0] lows);
    frame_t      f;
    int unsigned n;
    f.res = NONE;
    f.key = '0;
    n     = 0;
    for (int i = 0; i < 16; i++) begin
      if (lows[i]) begin
        n     = n + 1;
        f.key = KEY_W'(i);
      end
    end
    if (n == 1)
      f.res = SINGLE;
    else if (n > 1)
      f.res = MULTI;
    return f;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running N-bit prescaler; o_tick is high for the one cycle in which
// the count is all ones, i.e. once every 2**N clocks.
module scan_tick_gen #(
  parameter int N = 18
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + N'(1);
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/scan_key_matrix.sv
// Time-multiplexed 4x4 keypad scanner with frame-based debounce.
// Optional auto-repeat is enabled by defining KEY_REPEAT_EN.
module scan_key_matrix
  import key_scan_pkg::*;
#(
  parameter int N          = 18,
  parameter int DB_FRAMES  = 4,
  parameter int RPT_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [3:0] DB_LAST = 4'(DB_FRAMES - 1);

  if (DB_FRAMES < 1 || DB_FRAMES > 15 || RPT_FRAMES < 1) begin : g_cfg_err
    $error("scan_key_matrix: DB_FRAMES must be 1..15 and RPT_FRAMES >= 1");
  end

  logic             w_tick;
  logic             w_frame_end;
  logic [1:0]       w_col_nxt;
  logic [15:0]      w_lows;
  frame_t           w_frame;
  logic             w_match;

  logic [3:0]       r_row_p0;
  logic [3:0]       r_row_p1;
  logic [2:0][3:0]  r_lows_p2;
  logic [KEY_W-1:0] r_cand;

  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_out;
  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_down;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(RPT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_FRAMES - 1);
  logic [RPT_W-1:0] r_rpt_cnt;
`endif

  scan_tick_gen #(.N(N)) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  assign w_col_nxt   = r_col_idx + 2'd1;
  assign w_frame_end = w_tick && (r_col_idx == 2'd3);

  // Stage p0/p1: two-flop synchronizer for the asynchronous row returns
  always_ff @(posedge clk) begin
    r_row_p0 <= row_in;
    r_row_p1 <= r_row_p0;
  end

  // Stage p2: per-column row captures for columns 0..2 of the current frame
  always_ff @(posedge clk) begin
    if (w_tick && (r_col_idx != 2'd3))
      r_lows_p2[r_col_idx] <= ~r_row_p1;
    if (w_frame_end && (r_state == IDLE) && (w_frame.res == SINGLE))
      r_cand <= w_frame.key;
  end

  // Column 3 is taken straight from the synchronizer at the frame-ending tick.
  always_comb begin
    w_lows = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++)
        w_lows[r*4 + c] = r_lows_p2[c][r];
      w_lows[r*4 + 3] = ~r_row_p1[r];
    end
  end

  assign w_frame = classify(w_lows);
  assign w_match = (w_frame.res == SINGLE) && (w_frame.key == r_key_code);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_idx   <= 2'd0;
      r_col_out   <= COL_PAT[0];
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rpt_cnt   <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        r_col_idx <= w_col_nxt;
        r_col_out <= COL_PAT[w_col_nxt];
      end
      if (w_frame_end) begin
        case (r_state)
          IDLE: begin
            if (w_frame.res == SINGLE) begin
              if (DB_LAST == 4'd0) begin
                r_state     <= PRESSED;
                r_key_code  <= w_frame.key;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= 4'd0;
`ifdef KEY_REPEAT_EN
                r_rpt_cnt   <= '0;
`endif
              end else begin
                r_state <= DEBOUNCE;
                r_cnt   <= 4'd1;
              end
            end
          end
          DEBOUNCE: begin
            if ((w_frame.res == SINGLE) && (w_frame.key == r_cand)) begin
              if (r_cnt == DB_LAST) begin
                r_state     <= PRESSED;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= 4'd0;
`ifdef KEY_REPEAT_EN
                r_rpt_cnt   <= '0;
`endif
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= IDLE;
              r_cnt   <= 4'd0;
            end
          end
          PRESSED: begin
            if (w_match || (w_frame.res == MULTI)) begin
`ifdef KEY_REPEAT_EN
              if (w_match) begin
                if (r_rpt_cnt == RPT_LAST) begin
                  r_rpt_cnt   <= '0;
                  r_key_valid <= 1'b1;
                end else begin
                  r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                end
              end
`endif
            end else if (DB_LAST == 4'd0) begin
              r_state    <= IDLE;
              r_key_down <= 1'b0;
              r_cnt      <= 4'd0;
            end else begin
              r_state <= REL_DB;
              r_cnt   <= 4'd1;
`ifdef KEY_REPEAT_EN
              r_rpt_cnt <= '0;
`endif
            end
          end
          REL_DB: begin
`ifdef KEY_REPEAT_EN
            r_rpt_cnt <= '0;
`endif
            if (w_match || (w_frame.res == MULTI)) begin
              r_state <= PRESSED;
              r_cnt   <= 4'd0;
            end else if (r_cnt == DB_LAST) begin
              r_state    <= IDLE;
              r_key_down <= 1'b0;
              r_cnt      <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;

endmodule

// File: tb/tb_scan_key_matrix.sv
// Bench for scan_key_matrix (N=4, DB_FRAMES=3, RPT_FRAMES=4): a keypad model
// drives the rows and a strobe scoreboard checks code and arrival cycle.
module tb_scan_key_matrix;

  localparam int FRAME = 64;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys = '0;
  logic [3:0]  pat [0:3];
  exp_t        q [$];
  int          cyc = 0;
  int          fr = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_vld = 1'b0;

  scan_key_matrix #(.N(4), .DB_FRAMES(3), .RPT_FRAMES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Keypad: a row reads low when any pressed key on it sits in a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if ((cyc % 16) == 8)
        chk("col_out", {28'd0, col_out}, {28'd0, pat[(cyc / 16) % 4]});
      if (key_valid) begin
        chk("vld_gap", {31'd0, prev_vld}, 32'd0);
        if (q.size() == 0) begin
          chk("strobe_unexp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("strobe_code", {28'd0, key_code}, {28'd0, e.code});
          chk("strobe_cyc", cyc, e.cyc);
        end
      end
      prev_vld = key_valid;
    end else begin
      prev_vld = 1'b0;
    end
  end

  task automatic run(input int n);
    repeat (FRAME * n) @(posedge clk);
    #1;
    fr += n;
  endtask

  task automatic expect_press(input logic [3:0] code, input int frames_ahead);
    exp_t e;
    e.code = code;
    e.cyc  = FRAME * (fr + frames_ahead);
    q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    fr = 0;
  endtask

  task automatic chk_state(input string tag, input logic down, input logic [3:0] code);
    chk({tag, "_down"}, {31'd0, key_down}, {31'd0, down});
    chk({tag, "_code"}, {28'd0, key_code}, {28'd0, code});
  endtask

  initial begin
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    fr = 0;
    chk("rst_col", {28'd0, col_out}, 32'h0000000e);
    chk("rst_vld", {31'd0, key_valid}, 32'd0);
    chk_state("rst", 1'b0, 4'h0);

    // Idle keypad: rotation only, no strobes.
    run(10);
    chk_state("idle", 1'b0, 4'h0);

    // Key row1/col2 held five frames, then released.
    keys = 16'h0040;
    expect_press(4'h6, 3);
    run(5);
    chk_state("hold6", 1'b1, 4'h6);
    chk("hold6_pending", q.size(), 32'd0);
    keys = '0;
    run(2);
    chk("rel2_down", {31'd0, key_down}, 32'd1);
    run(1);
    chk("rel3_down", {31'd0, key_down}, 32'd0);

    // Bounce on key 9 never reaches three steady frames, then it does.
    keys = 16'h0200; run(2);
    keys = '0;       run(1);
    keys = 16'h0200; run(2);
    chk("bounce_down", {31'd0, key_down}, 32'd0);
    keys = '0;       run(1);
    keys = 16'h0200;
    expect_press(4'h9, 3);
    run(3);
    keys = '0;
    run(3);
    chk_state("bounce_done", 1'b0, 4'h9);
    chk("bounce_pending", q.size(), 32'd0);

    // Chord in column 0 is MULTI and must not start a press.
    keys = 16'h1001; run(4);
    chk_state("multi", 1'b0, 4'h9);
    keys = '0; run(1);

    // Key 0 accepted, then a second key joins while held.
    keys = 16'h0001;
    expect_press(4'h0, 3);
    run(3);
    keys = 16'h0021; run(2);
    chk_state("chord_held", 1'b1, 4'h0);
    chk("key0_pending", q.size(), 32'd0);

    // Short release and re-press of the same key stays down without a strobe.
    keys = '0;       run(2);
    keys = 16'h0001; run(2);
    chk_state("repress", 1'b1, 4'h0);
    keys = '0;       run(3);
    chk("rel_key0", {31'd0, key_down}, 32'd0);

    // Corner key F.
    keys = 16'h8000;
    expect_press(4'hF, 3);
    run(3);
    keys = '0;
    run(3);
    chk_state("keyF", 1'b0, 4'hF);
    chk("keyF_pending", q.size(), 32'd0);

    // Reset in the middle of a debounce discards it.
    keys = 16'h0008;
    run(2);
    repeat (20) @(posedge clk);
    pulse_reset();
    chk("mid_rst_col", {28'd0, col_out}, 32'h0000000e);
    chk("mid_rst_vld", {31'd0, key_valid}, 32'd0);
    chk_state("mid_rst", 1'b0, 4'h0);
    expect_press(4'h3, 3);
`ifdef KEY_REPEAT_EN
    expect_press(4'h3, 7);
    expect_press(4'h3, 11);
`endif
    run(12);
    chk_state("after_rst", 1'b1, 4'h3);
    keys = '0;
    run(3);
    chk("final_down", {31'd0, key_down}, 32'd0);
    chk("final_pending", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
